// File: rtl/pipe_mux_nx1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_pkg                                                              |
// | Mode encodings and the select-width helper for pipe_mux_nx1.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // A select index needs at least one bit, even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mux_nx1_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Rotating-priority search: first request above ptr, wrapping at N.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    int   w_idx;
    logic w_found;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int j = N; j >= 1; j--) begin
            w_idx = (int'(ptr) + j) % N;
            if (req[w_idx]) begin
                w_found = 1'b1;
                grant   = SEL_W'(w_idx);
            end
        end
        grant_valid = w_found && en;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_mux_nx1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_mux_nx1                                                         |
// | N-input registered mux with valid/ready on every channel and a       |
// | one-entry output buffer; select-steered or round-robin.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_mux_nx1
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MUX_MODE_SEL,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             r_state;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_src;

    logic [SEL_W-1:0] w_g;
    logic             w_gv;
    logic             w_gin_valid;
    logic [WIDTH-1:0] w_gin_data;
    logic             w_can_load;
    logic             w_load_ok;
    logic             w_accept;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic             w_sel_unused;

            assign w_sel_unused = ^sel;

            rr_arbiter #(
                .N     (N),
                .SEL_W (SEL_W)
            ) u_arb (
                .req         (in_valid),
                .ptr         (r_ptr),
                .en          (1'b1),
                .grant       (w_g),
                .grant_valid (w_gv)
            );

            // Channel 0 gets first priority after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= SEL_W'(N - 1);
                end else if (w_accept) begin
                    r_ptr <= w_g;
                end
            end
        end else begin : g_sel
            assign w_g  = sel;
            assign w_gv = ({1'b0, sel} < (SEL_W + 1)'(N));
        end
    endgenerate

    always_comb begin
        w_gin_valid = 1'b0;
        w_gin_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_g == SEL_W'(i)) begin
                w_gin_valid = in_valid[i];
                w_gin_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // out_ready feeds in_ready combinationally; integrators must budget it.
    assign w_can_load = (r_state == ST_EMPTY) || out_ready;
    assign w_load_ok  = rst_n && w_can_load && w_gv &&
                        ((MODE == MUX_MODE_SEL) || w_gin_valid);
    assign w_accept   = w_load_ok && w_gin_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_load_ok && (w_g == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_data  <= w_gin_data;
                        r_src   <= w_g;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_data <= w_gin_data;
                        r_src  <= w_g;
                    end else if (out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_nx1.sv
`default_nettype none
// Bench for pipe_mux_nx1: three instances (N=4 select, N=4 round-robin,
// N=3 select) checked every cycle against a transaction-level model.
module tb_pipe_mux_nx1;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] a_data;  logic [3:0] a_valid, a_ready;  logic [1:0] a_sel, a_osrc;
    logic [31:0]  a_odata; logic a_ovalid, a_ordy;
    logic [127:0] b_data;  logic [3:0] b_valid, b_ready;  logic [1:0] b_sel, b_osrc;
    logic [31:0]  b_odata; logic b_ovalid, b_ordy;
    logic [95:0]  c_data;  logic [2:0] c_valid, c_ready;  logic [1:0] c_sel, c_osrc;
    logic [31:0]  c_odata; logic c_ovalid, c_ordy;

    pipe_mux_nx1 #(.WIDTH(32), .N(4), .MODE(MUX_MODE_SEL)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy), .out_src(a_osrc));
    pipe_mux_nx1 #(.WIDTH(32), .N(4), .MODE(MUX_MODE_RR)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy), .out_src(b_osrc));
    pipe_mux_nx1 #(.WIDTH(32), .N(3), .MODE(MUX_MODE_SEL)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_ordy), .out_src(c_osrc));

    int n_cmp = 0;
    int n_fail = 0;

    // Model state per instance: buffered word, its source, and arbitration pointer.
    bit          mv[3]   = '{0, 0, 0};
    logic [31:0] md[3]   = '{0, 0, 0};
    int          ms[3]   = '{0, 0, 0};
    int          mptr[3] = '{3, 3, 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int k, input int n, input int mode, input int sel,
                        input logic [15:0] v, input logic [511:0] d, input bit ordy,
                        input logic [15:0] rdy, input bit ov, input logic [31:0] od,
                        input int os, input string tag);
        int g;
        logic [15:0] exp_rdy;
        if (!rst_n) begin
            mv[k] = 0; md[k] = '0; ms[k] = 0; mptr[k] = n - 1;
        end
        check({tag, ".out_valid"}, 32'(ov), 32'(mv[k]));
        check({tag, ".out_data"}, od, md[k]);
        check({tag, ".out_src"}, 32'(os), 32'(ms[k]));
        g = -1;
        if (mode == MUX_MODE_SEL) begin
            if (sel < n) g = sel;
        end else begin
            for (int j = 1; j <= n; j++) begin
                int idx;
                idx = (mptr[k] + j) % n;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (rst_n && (!mv[k] || ordy) && g >= 0) exp_rdy[g] = 1'b1;
        check({tag, ".in_ready"}, 32'(rdy), 32'(exp_rdy));
        if (rst_n) begin
            if (g >= 0 && exp_rdy[g] && v[g]) begin
                mv[k] = 1; md[k] = d[g*32 +: 32]; ms[k] = g;
                if (mode == MUX_MODE_RR) mptr[k] = g;
            end else if (ordy) begin
                mv[k] = 0;
            end
        end
    endtask

    // Inputs only change just after a rising edge, so the falling edge sees
    // both settled outputs and the inputs the next rising edge will use.
    always @(negedge clk) begin
        step(0, 4, MUX_MODE_SEL, int'(a_sel), 16'(a_valid), 512'(a_data), a_ordy,
             16'(a_ready), a_ovalid, a_odata, int'(a_osrc), "A");
        step(1, 4, MUX_MODE_RR, int'(b_sel), 16'(b_valid), 512'(b_data), b_ordy,
             16'(b_ready), b_ovalid, b_odata, int'(b_osrc), "B");
        step(2, 3, MUX_MODE_SEL, int'(c_sel), 16'(c_valid), 512'(c_data), c_ordy,
             16'(c_ready), c_ovalid, c_odata, int'(c_osrc), "C");
    end

    initial begin
        int skip_seq[4];
        skip_seq = '{1, 3, 1, 3};
        a_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'hA0A0_A0A0};
        b_data = {32'hB333_0003, 32'hB222_0002, 32'hB111_0001, 32'hB000_0000};
        c_data = {32'hC222_0002, 32'hC111_0001, 32'hC000_0000};
        a_valid = 4'hF; b_valid = 4'hF; c_valid = 3'h7;
        a_sel = 2'd2; b_sel = 2'd0; c_sel = 2'd3;
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;

        // Reset holds every ready low even with all channels valid.
        repeat (3) @(posedge clk);
        #1;
        check("rst.a_ready", 32'(a_ready), 32'd0);
        check("rst.b_ready", 32'(b_ready), 32'd0);
        check("rst.c_ready", 32'(c_ready), 32'd0);
        check("rst.a_ovalid", 32'(a_ovalid), 32'd0);
        check("rst.a_odata", a_odata, 32'd0);
        rst_n = 1'b1; a_valid = 4'b0100; b_valid = 4'h0;

        @(posedge clk); #1;
        check("first.a_ovalid", 32'(a_ovalid), 32'd1);
        check("first.a_odata", a_odata, 32'hDEAD_BEEF);
        check("first.a_osrc", 32'(a_osrc), 32'd2);

        // Backpressure: the buffered word must hold for five stalled cycles.
        a_ordy = 1'b0; a_valid = 4'hF; a_sel = 2'd1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp.a_ready", 32'(a_ready), 32'd0);
            check("bp.a_odata", a_odata, 32'hDEAD_BEEF);
            check("bp.a_ovalid", 32'(a_ovalid), 32'd1);
        end
        a_ordy = 1'b1; #1;
        check("bp.release_ready", 32'(a_ready), 32'b0010);
        @(posedge clk); #1;
        check("bp.swap_ovalid", 32'(a_ovalid), 32'd1);
        check("bp.swap_odata", a_odata, 32'h1111_1111);
        check("bp.swap_osrc", 32'(a_osrc), 32'd1);
        a_valid = 4'h0;

        // Round robin with every channel requesting.
        b_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rr.seq_src", 32'(b_osrc), 32'(i % 4));
            check("rr.seq_valid", 32'(b_ovalid), 32'd1);
        end
        b_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rr.skip_src", 32'(b_osrc), 32'(skip_seq[i]));
        end
        b_valid = 4'b0010;
        repeat (3) begin
            @(posedge clk); #1;
            check("rr.single_src", 32'(b_osrc), 32'd1);
            check("rr.single_valid", 32'(b_ovalid), 32'd1);
        end
        b_valid = 4'h0;

        // Out-of-range select on the three-channel instance never grants.
        repeat (3) begin
            @(posedge clk); #1;
            check("badsel.c_ready", 32'(c_ready), 32'd0);
            check("badsel.c_ovalid", 32'(c_ovalid), 32'd0);
        end

        // Reset asserted while a stalled word is buffered.
        a_ordy = 1'b0; a_valid = 4'hF; a_sel = 2'd3;
        @(posedge clk); #1;
        check("midrst.pre_ovalid", 32'(a_ovalid), 32'd1);
        check("midrst.pre_odata", a_odata, 32'h3333_3333);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("midrst.ovalid", 32'(a_ovalid), 32'd0);
        check("midrst.odata", a_odata, 32'd0);
        check("midrst.osrc", 32'(a_osrc), 32'd0);
        check("midrst.ready", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; a_valid = 4'h0; a_ordy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_mux_nx1.md
# pipe_mux_nx1

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the combinational 2:1 datapath mux into a channel-selecting pipeline stage, with a one-entry output buffer and either an explicit select or round-robin arbitration. It is used wherever several producers share one pipeline consumer, such as writeback source merging or multi-source fetch requests.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (2..16)
- MODE, 0, 0 = select-steered (sel picks the channel), 1 = round-robin arbitration (sel ignored)
- SEL_W, localparam = max(1, $clog2(N)), select/source index width

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i presents a word
- in_ready  out  N  channel i word is accepted this cycle when in_valid[i] is also high
- sel  in  SEL_W  channel select; used only when MODE=0
- out_data  out  WIDTH  buffered word
- out_valid  out  1  buffer holds a word
- out_ready  in  1  consumer takes the word this cycle
- out_src  out  SEL_W  index of the channel that supplied out_data

## Operation
- Two-state FSM, encoded by out_valid:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without a simultaneous accept.
  - FULL -> FULL on drain with a simultaneous accept, or when stalled.
- can_load = !out_valid || out_ready.
- Grant index g:
  - MODE=0: g = sel.
  - MODE=1: g = the first channel with in_valid set, searching from rr_ptr+1 upward with wrap modulo N.
- in_ready[i] = can_load && (i == g). In MODE=1, in_ready[i] also requires in_valid[i]. At most one in_ready bit is high in any cycle; in_ready is combinational from the inputs and state.
- Accept = in_valid[g] && in_ready[g]. On accept: out_data <= channel g data, out_src <= g, out_valid <= 1.
- Drain without accept: out_valid <= 0. out_data and out_src keep their last value.
- Stall (out_valid && !out_ready): out_data, out_src and out_valid hold. No in_ready bit is asserted.
- rr_ptr (MODE=1 only) updates to g on each accept and is unchanged otherwise, which gives fair rotation.
- sel >= N (non-power-of-2 N): no channel is granted, nothing is accepted, and all in_ready bits are 0.
- An input whose in_valid is low is never accepted, even when it is granted in MODE=0.

## Timing
- Reset values (asynchronous assertion, synchronous-safe release):
  - out_valid = 0, out_data = 0, out_src = 0
  - rr_ptr = N-1, so channel 0 has first priority after reset
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- Throughput: 1 word/cycle when out_ready is held high (accept and drain in the same cycle).
- Accept and drain in the same cycle: the new word replaces the old one and out_valid stays 1.
- Reset mid-operation: the buffered word is discarded. No in_ready is asserted while rst_n = 0.
- No combinational path from out_ready to out_data/out_valid. The path out_ready -> in_ready is combinational and documented for integrators.

## Structure
- Shared package mux_pkg:
  - MUX_MODE_SEL = 0, MUX_MODE_RR = 1
  - function clog2_min1 for SEL_W
- Sub-module rr_arbiter #(N):
  - Inputs: req[N-1:0], ptr, en. Outputs: grant index, grant_valid.
  - Rotating-priority search, purely combinational. Instantiated only under MODE=1 via generate.
- Top holds the output register, the FSM and rr_ptr.

## Test plan
- Reset: with rst_n=0 and all in_valid=1, all in_ready=0 and out_valid=0. After release with MODE=0, sel=2 and in_data ch2=32'hDEAD_BEEF, out_data=32'hDEAD_BEEF and out_src=2 one cycle later.
- Backpressure (MODE=0): with out_ready=0 and out_valid=1, in_ready=0 and out_data is stable for 5 cycles. When out_ready rises, the drain and the next accept occur in the same cycle and out_valid stays 1.
- Round-robin (MODE=1, N=4): all in_valid=1 and out_ready=1 give out_src sequence 0,1,2,3,0,1.
- Round-robin skip (MODE=1): with only channels 1 and 3 valid, out_src alternates 1,3,1,3. When channel 3 drops, channel 1 is granted every cycle.
- Invalid sel (N=3, MODE=0): sel=3 keeps in_ready=0 and out_valid=0 for all cycles.
- Mid-operation reset: assert rst_n=0 while out_valid=1 and out_ready=0. out_valid goes to 0 immediately (asynchronously) and out_data reads 0.
